ifu: RTL and testbench

Pipelined instruction fetch unit that replaces the core's fixed PC register and combinational instruction ROM with a latency-tolerant fetch path. It issues sequential 4-byte fetches over a valid/ready memory request port and accepts in-order responses. Fetched {pc, inst, err} tuples are buffered in a parametrised slot queue and presented to decode over a valid/ready port. A redirect input (taken branch, jal/jalr, trap) flushes the queue and discards stale in-flight responses.

---
 rtl/ifu_pkg.sv | 14 +
 rtl/ifu_if.sv | 36 +++
 rtl/ifu_queue.sv | 94 +++++++++
 rtl/ifu.sv | 88 ++++++++
 tb/tb_ifu.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared defaults and helpers for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 64;
    localparam int unsigned INST_WIDTH_DEF = 32;
    localparam logic [63:0] PC_RST         = 64'h0000_0000_8000_0000;
    localparam int unsigned IFU_DEPTH      = 4;

    // Counters must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bundle: memory request/response port, redirect input and decode-side output port.
interface ifu_if
    import ifu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned INST_WIDTH = INST_WIDTH_DEF
);

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_resp_valid;
    logic [INST_WIDTH-1:0] mem_resp_data;
    logic                  mem_resp_err;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [INST_WIDTH-1:0] out_inst;
    logic                  out_err;

    // master is the fetch unit; slave is the memory/decode/branch environment.
    modport master (
        output mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst, out_err,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst, out_err,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/ifu_queue.sv
// Slot ring for fetched {pc, inst, err}: slots are allocated at issue, filled in order
// by responses, popped at the head, and flushed wholesale on redirect.
module ifu_queue
    import ifu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned INST_WIDTH = INST_WIDTH_DEF,
    parameter int unsigned DEPTH      = IFU_DEPTH,
    localparam int unsigned CW        = cnt_width(DEPTH),
    localparam int unsigned PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_i,
    input  logic [ADDR_WIDTH-1:0] alloc_pc_i,
    input  logic                  fill_i,
    input  logic [INST_WIDTH-1:0] fill_inst_i,
    input  logic                  fill_err_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [CW-1:0]         count_o,
    output logic                  head_valid_o,
    output logic [ADDR_WIDTH-1:0] head_pc_o,
    output logic [INST_WIDTH-1:0] head_inst_o,
    output logic                  head_err_o
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
        logic                  err;
        logic                  filled;
    } slot_t;

    slot_t         slot_q [DEPTH];
    logic [PW-1:0] head_q, tail_q, fill_q;
    logic [CW-1:0] count_q, count_d;

    // NOTE: count_d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = CW'(alloc_i);
        end else begin
            count_d = count_q - CW'(pop_i) + CW'(alloc_i);
        end
    end

    // NOTE: the slot array is reset too, so the head tuple reads as zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                head_q <= tail_q;
                fill_q <= tail_q;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    slot_q[i].filled <= 1'b0;
                end
            end else begin
                if (fill_i) begin
                    slot_q[fill_q].inst   <= fill_inst_i;
                    slot_q[fill_q].err    <= fill_err_i;
                    slot_q[fill_q].filled <= 1'b1;
                    fill_q                <= fill_q + PW'(1);
                end
                if (pop_i) begin
                    slot_q[head_q].filled <= 1'b0;
                    head_q                <= head_q + PW'(1);
                end
            end
            // Allocation lands after a flush, so a redirect target can claim the first fresh slot.
            if (alloc_i) begin
                slot_q[tail_q].pc     <= alloc_pc_i;
                slot_q[tail_q].filled <= 1'b0;
                tail_q                <= tail_q + PW'(1);
            end
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = slot_q[head_q].filled;
    assign head_pc_o    = slot_q[head_q].pc;
    assign head_inst_o  = slot_q[head_q].inst;
    assign head_err_o   = slot_q[head_q].err;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: sequential 4-byte fetches, in-order responses into a slot ring,
// redirect flushes the ring and discards responses for requests issued before it.
module ifu
    import ifu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned           INST_WIDTH = INST_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(PC_RST),
    parameter int unsigned           DEPTH      = IFU_DEPTH
) (
    input logic   clk,
    input logic   rst,
    ifu_if.master bus
);

    localparam int unsigned CW = cnt_width(DEPTH);

    logic                  req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, issue_pc;
    logic [CW-1:0]         inflight_q, inflight_d, drop_q, drop_d;
    logic [CW-1:0]         alloc_cnt, alloc_after;
    logic                  req_held, resp_fire, resp_drop, resp_fill, pop, issue, head_valid;

    assign req_held  = req_valid_q && !bus.mem_req_ready;
    assign resp_fire = bus.mem_resp_valid && (inflight_q != '0);
    assign resp_drop = resp_fire && (drop_q != '0);
    assign resp_fill = resp_fire && !resp_drop;
    assign pop       = head_valid && bus.out_ready;

    // NOTE: next-state logic uses blocking '=' in always_comb; state registers update with '<=' only.
    always_comb begin
        issue_pc    = bus.redirect_valid ? (bus.redirect_pc & ~ADDR_WIDTH'(3)) : fetch_pc_q;
        alloc_after = bus.redirect_valid ? '0 : alloc_cnt - CW'(pop);
        // On redirect every issued-but-unanswered request becomes a drop, the held one included.
        drop_d      = bus.redirect_valid ? inflight_q - CW'(resp_fire) : drop_q - CW'(resp_drop);
        issue       = !req_held && (({1'b0, alloc_after} + {1'b0, drop_d}) < (CW + 1)'(DEPTH));
        req_valid_d = issue || req_held;
        req_addr_d  = issue ? issue_pc : req_addr_q;
        fetch_pc_d  = issue ? issue_pc + ADDR_WIDTH'(4) : issue_pc;
        inflight_d  = inflight_q + CW'(issue) - CW'(resp_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            inflight_q  <= '0;
            drop_q      <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
        end
    end

    ifu_queue #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .INST_WIDTH(INST_WIDTH),
        .DEPTH     (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .alloc_i     (issue),
        .alloc_pc_i  (issue_pc),
        .fill_i      (resp_fill),
        .fill_inst_i (bus.mem_resp_data),
        .fill_err_i  (bus.mem_resp_err),
        .pop_i       (pop),
        .flush_i     (bus.redirect_valid),
        .count_o     (alloc_cnt),
        .head_valid_o(head_valid),
        .head_pc_o   (bus.out_pc),
        .head_inst_o (bus.out_inst),
        .head_err_o  (bus.out_err)
    );

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.out_valid     = head_valid;

    resp_needs_inflight: assert property (@(posedge clk) disable iff (rst)
        !(bus.mem_resp_valid && inflight_q == '0));

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a small in-order memory model with fixed latency, request/output logs,
// a table of expected stream outputs and hand-written redirect/backpressure/reset sequences.
module tb_ifu;

    localparam int unsigned AW     = 64;
    localparam int unsigned IW     = 32;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [63:0] NO_ERR = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        err;
        int          cyc;
    } out_t;

    typedef struct {
        logic [63:0] addr;
        int          cyc;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifu_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

    ifu #(
        .ADDR_WIDTH(AW),
        .INST_WIDTH(IW),
        .RESET_PC  (RST_PC),
        .DEPTH     (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    out_t        out_log[$];
    req_t        req_log[$];
    req_t        pend[$];
    int          cyc, n_cmp, n_bad;
    int          lat, ready_from, redir_cyc;
    logic        out_rdy_k, prev_held;
    logic [63:0] redir_pc_k, err_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic out_t get_out(input int i);
        out_t o;
        o = '{64'hDEAD_DEAD_DEAD_DEAD, 32'hDEAD_DEAD, 1'bx, -1};
        if (i < out_log.size()) o = out_log[i];
        return o;
    endfunction

    function automatic req_t get_req(input int i);
        req_t r;
        r = '{64'hDEAD_DEAD_DEAD_DEAD, -1};
        if (i < req_log.size()) r = req_log[i];
        return r;
    endfunction

    // One cycle: drive inputs at the negedge, then log the handshakes the next posedge will see.
    task automatic tick();
        @(negedge clk);
        cyc++;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;
        if (rst) begin
            pend.delete();
            prev_held = 1'b0;
        end else if (pend.size() > 0 && pend[0].cyc <= cyc) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = ~pend[0].addr[31:0];
            bus.mem_resp_err   = (pend[0].addr == err_addr);
            pend.delete(0);
        end
        bus.mem_req_ready  = (cyc >= ready_from);
        bus.out_ready      = out_rdy_k;
        bus.redirect_valid = (cyc == redir_cyc);
        bus.redirect_pc    = redir_pc_k;
        if (!rst) begin
            if (bus.mem_req_valid && !prev_held)
                req_log.push_back('{bus.mem_req_addr, cyc});
            if (bus.mem_req_valid && bus.mem_req_ready)
                pend.push_back('{bus.mem_req_addr, cyc + lat});
            if (bus.out_valid && bus.out_ready)
                out_log.push_back('{bus.out_pc, bus.out_inst, bus.out_err, cyc});
            prev_held = bus.mem_req_valid && !bus.mem_req_ready;
        end
    endtask

    task automatic set_knobs(input int l, input int rf, input logic ordy, input int rc,
                             input logic [63:0] rpc, input logic [63:0] ea);
        lat        = l;
        ready_from = rf;
        out_rdy_k  = ordy;
        redir_cyc  = rc;
        redir_pc_k = rpc;
        err_addr   = ea;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
    endtask

    // The negedge where rst drops is cycle 0; the first request is visible in cycle 1.
    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        out_log.delete();
        req_log.delete();
        pend.delete();
        prev_held          = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.mem_req_ready  = (cyc >= ready_from);
        bus.out_ready      = out_rdy_k;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        out_t t1 [6];
        out_t o;
        req_t r;

        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst   = 1'b1;
        set_knobs(1, 0, 1'b1, -1, 64'h0, NO_ERR);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;

        // Reset state.
        do_reset();
        check("rst mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst mem_req_addr", bus.mem_req_addr, RST_PC);
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst out_pc", bus.out_pc, 64'd0);
        check("rst out_inst", 64'(bus.out_inst), 64'd0);
        check("rst out_err", 64'(bus.out_err), 64'd0);

        // Streaming at one per cycle; the second fetch returns an access fault.
        t1[0] = '{64'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3};
        t1[1] = '{64'h8000_0004, 32'h7FFF_FFFB, 1'b1, 4};
        t1[2] = '{64'h8000_0008, 32'h7FFF_FFF7, 1'b0, 5};
        t1[3] = '{64'h8000_000C, 32'h7FFF_FFF3, 1'b0, 6};
        t1[4] = '{64'h8000_0010, 32'h7FFF_FFEF, 1'b0, 7};
        t1[5] = '{64'h8000_0014, 32'h7FFF_FFEB, 1'b0, 8};
        set_knobs(1, 0, 1'b1, -1, 64'h0, 64'h8000_0004);
        release_rst();
        repeat (10) tick();
        check("stream pop count", 64'(out_log.size()), 64'd8);
        for (int i = 0; i < 6; i++) begin
            o = get_out(i);
            check($sformatf("stream[%0d] pc", i), o.pc, t1[i].pc);
            check($sformatf("stream[%0d] inst", i), 64'(o.inst), 64'(t1[i].inst));
            check($sformatf("stream[%0d] err", i), 64'(o.err), 64'(t1[i].err));
            check($sformatf("stream[%0d] cycle", i), 64'(o.cyc), 64'(t1[i].cyc));
        end

        // Decode stalled: exactly DEPTH requests, then issue resumes right after the first pop.
        do_reset();
        set_knobs(1, 0, 1'b0, -1, 64'h0, NO_ERR);
        release_rst();
        repeat (8) tick();
        check("full: requests issued", 64'(req_log.size()), 64'd4);
        check("full: mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("full: out_valid", 64'(bus.out_valid), 64'd1);
        out_rdy_k = 1'b1;
        repeat (6) tick();
        o = get_out(0);
        check("full: first pop cycle", 64'(o.cyc), 64'd9);
        r = get_req(4);
        check("full: resumed addr", r.addr, 64'h8000_0010);
        check("full: resumed cycle", 64'(r.cyc), 64'd10);
        for (int i = 0; i < 4; i++) begin
            o = get_out(i);
            check($sformatf("full: drain[%0d] pc", i), o.pc, RST_PC + 64'(4 * i));
        end

        // Held request across a redirect to an unaligned target.
        do_reset();
        set_knobs(1, 6, 1'b1, 2, 64'h8000_1002, NO_ERR);
        release_rst();
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("held c%0d valid", c), 64'(bus.mem_req_valid), 64'd1);
            check($sformatf("held c%0d addr", c), bus.mem_req_addr, 64'h8000_0000);
        end
        repeat (7) tick();
        r = get_req(1);
        check("held: next req addr", r.addr, 64'h8000_1000);
        check("held: next req cycle", 64'(r.cyc), 64'd7);
        o = get_out(0);
        check("held: first out_pc", o.pc, 64'h8000_1000);
        check("held: first out_inst", 64'(o.inst), 64'h7FFF_EFFF);
        check("held: first out cycle", 64'(o.cyc), 64'd9);

        // Redirect with three in flight at 4-cycle latency.
        do_reset();
        set_knobs(4, 0, 1'b1, 3, 64'h8000_2000, NO_ERR);
        release_rst();
        repeat (5) tick();
        check("drop: issue blocked", 64'(bus.mem_req_valid), 64'd0);
        repeat (10) tick();
        r = get_req(3);
        check("drop: target addr", r.addr, 64'h8000_2000);
        check("drop: target cycle", 64'(r.cyc), 64'd4);
        r = get_req(4);
        check("drop: 2nd addr", r.addr, 64'h8000_2004);
        check("drop: 2nd cycle", 64'(r.cyc), 64'd6);
        r = get_req(5);
        check("drop: 3rd cycle", 64'(r.cyc), 64'd7);
        o = get_out(0);
        check("drop: first out_pc", o.pc, 64'h8000_2000);
        check("drop: first out cycle", 64'(o.cyc), 64'd9);
        o = get_out(1);
        check("drop: second out_pc", o.pc, 64'h8000_2004);

        // Reset in the middle of a stream with entries queued.
        do_reset();
        set_knobs(1, 0, 1'b0, -1, 64'h0, NO_ERR);
        release_rst();
        repeat (4) tick();
        check("midrst: queued before", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        tick();
        check("midrst: out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst: mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("midrst: out_pc", bus.out_pc, 64'd0);
        release_rst();
        tick();
        r = get_req(0);
        check("midrst: restart addr", r.addr, RST_PC);
        check("midrst: restart cycle", 64'(r.cyc), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
